// File: rtl/clkdiv_pkg.sv
// Shared configuration type and legality check for the programmable clock divider.
package clkdiv_pkg;

  localparam int unsigned MaxWidth = 32;

  typedef struct packed {
    logic [MaxWidth-1:0] div;
    logic [MaxWidth-1:0] high;
  } clkdiv_cfg_t;

  // Builds a config from WIDTH-bit fields, dropping anything above the live width.
  function automatic clkdiv_cfg_t make_cfg(input int unsigned width,
                                           input logic [MaxWidth-1:0] div,
                                           input logic [MaxWidth-1:0] high);
    logic [MaxWidth-1:0] mask;
    clkdiv_cfg_t cfg;
    mask = (width >= MaxWidth) ? '1 : ((MaxWidth'(1) << width) - MaxWidth'(1));
    cfg.div  = div & mask;
    cfg.high = high & mask;
    return cfg;
  endfunction

  function automatic logic cfg_legal(input clkdiv_cfg_t cfg);
    return (cfg.div >= MaxWidth'(2)) && (cfg.high >= MaxWidth'(1)) &&
           (cfg.high <= cfg.div - MaxWidth'(1));
  endfunction

endpackage

// File: rtl/clkdiv_cfg_slot.sv
// Configuration handshake: one pending slot, registered ready and error pulse.
module clkdiv_cfg_slot
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             input_clk_digital,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  input  logic             take,
  output logic             cfg_ready,
  output logic             cfg_error,
  output logic             pending_full,
  output logic [WIDTH-1:0] pending_div,
  output logic [WIDTH-1:0] pending_high
);

  logic             full_q, full_d;
  logic             ready_q;
  logic             error_q;
  logic [WIDTH-1:0] div_q, high_q;
  logic             transfer, legal;
  clkdiv_cfg_t      offered;

  always_comb begin
    offered  = make_cfg(WIDTH, MaxWidth'(cfg_div), MaxWidth'(cfg_high));
    legal    = cfg_legal(offered);
    transfer = cfg_valid && ready_q;
    full_d   = full_q;
    if (take) full_d = 1'b0;
    if (transfer && legal) full_d = 1'b1;
  end

  always_ff @(posedge input_clk_digital) begin
    if (reset) begin
      full_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      div_q   <= '0;
      high_q  <= '0;
    end else begin
      full_q  <= full_d;
      // Ready tracks the slot one cycle later, so it drops after a legal transfer.
      ready_q <= !full_d;
      error_q <= transfer && !legal;
      if (transfer && legal) begin
        div_q  <= cfg_div;
        high_q <= cfg_high;
      end
    end
  end

  assign cfg_ready    = ready_q;
  assign cfg_error    = error_q;
  assign pending_full = full_q;
  assign pending_div  = div_q;
  assign pending_high = high_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable clock divider: period counter, registered divided clock and status pulses.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_DIV  = 4,
  parameter int unsigned DEFAULT_HIGH = 2
) (
  input  logic             input_clk_digital,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_high,
  output logic             cfg_ready,
  output logic             output_clk_digital,
  output logic             tick,
  output logic             cfg_applied,
  output logic             cfg_error
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("prog_clock_divider: WIDTH must be in 2..32");
  end
  if (DEFAULT_DIV < 2 || DEFAULT_HIGH < 1 || DEFAULT_HIGH > DEFAULT_DIV - 1) begin : g_bad_default
    $error("prog_clock_divider: illegal DEFAULT_DIV/DEFAULT_HIGH");
  end
  if (longint'(DEFAULT_DIV) >= (longint'(1) << WIDTH)) begin : g_bad_fit
    $error("prog_clock_divider: DEFAULT_DIV does not fit in WIDTH");
  end

  localparam logic [WIDTH-1:0] DefDiv  = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DefHigh = WIDTH'(DEFAULT_HIGH);

  logic [WIDTH-1:0] div_q, div_d, high_q, high_d, cnt_q, cnt_d;
  logic             clk_q, clk_d, tick_q, tick_d, applied_q, applied_d;
  logic             wrap, take, pend_full;
  logic [WIDTH-1:0] pend_div, pend_high;

  clkdiv_cfg_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .input_clk_digital(input_clk_digital),
    .reset            (reset),
    .cfg_valid        (cfg_valid),
    .cfg_div          (cfg_div),
    .cfg_high         (cfg_high),
    .take             (take),
    .cfg_ready        (cfg_ready),
    .cfg_error        (cfg_error),
    .pending_full     (pend_full),
    .pending_div      (pend_div),
    .pending_high     (pend_high)
  );

  always_comb begin
    div_d     = div_q;
    high_d    = high_q;
    cnt_d     = cnt_q;
    take      = 1'b0;
    applied_d = 1'b0;
    tick_d    = 1'b0;
    clk_d     = 1'b0;
    wrap      = (cnt_q == div_q - WIDTH'(1));
    if (enable) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_full) begin
          take      = 1'b1;
          applied_d = 1'b1;
          div_d     = pend_div;
          high_d    = pend_high;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      clk_d = (cnt_d < high_d);
    end else begin
      if (pend_full) begin
        take      = 1'b1;
        applied_d = 1'b1;
        div_d     = pend_div;
        high_d    = pend_high;
      end
      // Parking at div-1 makes the first enabled edge a wrap, giving a full first period.
      cnt_d = div_d - WIDTH'(1);
    end
  end

  always_ff @(posedge input_clk_digital) begin
    if (reset) begin
      div_q     <= DefDiv;
      high_q    <= DefHigh;
      cnt_q     <= DefDiv - WIDTH'(1);
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
      applied_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      high_q    <= high_d;
      cnt_q     <= cnt_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      applied_q <= applied_d;
    end
  end

  assign output_clk_digital = clk_q;
  assign tick               = tick_q;
  assign cfg_applied        = applied_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench: directed per-cycle vectors checked on a WIDTH=16 and a WIDTH=4 divider.
module tb_prog_clock_divider;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, enable, cfg_valid;
  logic [15:0] div16, high16;
  logic [3:0]  div4, high4;
  logic        rdy16, oclk16, tick16, app16, err16;
  logic        rdy4, oclk4, tick4, app4, err4;

  vec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  prog_clock_divider #(
    .WIDTH(16), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)
  ) dut16 (
    .input_clk_digital (clk),
    .reset             (reset),
    .enable            (enable),
    .cfg_valid         (cfg_valid),
    .cfg_div           (div16),
    .cfg_high          (high16),
    .cfg_ready         (rdy16),
    .output_clk_digital(oclk16),
    .tick              (tick16),
    .cfg_applied       (app16),
    .cfg_error         (err16)
  );

  prog_clock_divider #(
    .WIDTH(4), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)
  ) dut4 (
    .input_clk_digital (clk),
    .reset             (reset),
    .enable            (enable),
    .cfg_valid         (cfg_valid),
    .cfg_div           (div4),
    .cfg_high          (high4),
    .cfg_ready         (rdy4),
    .output_clk_digital(oclk4),
    .tick              (tick4),
    .cfg_applied       (app4),
    .cfg_error         (err4)
  );

  // Expected vector bits: {output_clk_digital, tick, cfg_applied, cfg_error, cfg_ready}.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      vec_t v;
      logic [4:0] o16, o4;
      v   = q.pop_front();
      o16 = {oclk16, tick16, app16, err16, rdy16};
      o4  = {oclk4, tick4, app4, err4, rdy4};
      vectors++;
      if (o16 !== v.exp) begin
        miscompares++;
        $display("FAIL %s w16: got %b want %b", v.name, o16, v.exp);
      end
      vectors++;
      if (o4 !== v.exp) begin
        miscompares++;
        $display("FAIL %s w4: got %b want %b", v.name, o4, v.exp);
      end
    end
  end

  task automatic step(input logic r, input logic en, input logic v, input int unsigned d,
                      input int unsigned h, input logic [4:0] e, input string n);
    vec_t item;
    reset     = r;
    enable    = en;
    cfg_valid = v;
    div16     = 16'(d);
    high16    = 16'(h);
    div4      = 4'(d);
    high4     = 4'(h);
    item.exp  = e;
    item.name = n;
    q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 5'b00000, "reset");
    step(0, 1, 0, 0, 0, 5'b11001, "first_edge");
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0, 0, 5'b10001, "def_hi");
      step(0, 1, 0, 0, 0, 5'b00001, "def_lo1");
      step(0, 1, 0, 0, 0, 5'b00001, "def_lo2");
      step(0, 1, 0, 0, 0, 5'b11001, "def_tick");
    end
    // Mid-period reconfiguration to 5/1.
    step(0, 1, 1, 5, 1, 5'b10000, "offer_5_1");
    step(0, 1, 0, 0, 0, 5'b00000, "old_period_a");
    step(0, 1, 0, 0, 0, 5'b00000, "old_period_b");
    step(0, 1, 0, 0, 0, 5'b11101, "apply_5_1");
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) step(0, 1, 0, 0, 0, 5'b00001, "new_lo");
      step(0, 1, 0, 0, 0, 5'b11001, "new_tick");
    end
    // Illegal offers: error pulse, ready stays high, pattern unchanged.
    step(0, 1, 1, 1, 1, 5'b00011, "bad_div1");
    step(0, 1, 0, 0, 0, 5'b00001, "after_bad1");
    step(0, 1, 1, 5, 5, 5'b00011, "bad_high");
    step(0, 1, 0, 0, 0, 5'b00001, "after_bad2");
    step(0, 1, 0, 0, 0, 5'b11001, "still_5");
    // Reset with a full slot discards it.
    step(0, 1, 1, 3, 2, 5'b00000, "offer_3_2");
    step(1, 1, 0, 0, 0, 5'b00000, "rst_full_a");
    step(1, 1, 0, 0, 0, 5'b00000, "rst_full_b");
    step(0, 1, 0, 0, 0, 5'b11001, "rst_release");
    step(0, 1, 0, 0, 0, 5'b10001, "rst_def_hi");
    step(0, 1, 0, 0, 0, 5'b00001, "rst_def_lo1");
    step(0, 1, 0, 0, 0, 5'b00001, "rst_def_lo2");
    step(0, 1, 0, 0, 0, 5'b11001, "no_apply");
    step(0, 1, 0, 0, 0, 5'b10001, "pre_disable");
    // Disable at cnt=1, apply 6/3 while stopped, then re-enable.
    step(0, 0, 0, 0, 0, 5'b00001, "dis_trunc");
    step(0, 0, 1, 6, 3, 5'b00000, "dis_offer");
    step(0, 0, 0, 0, 0, 5'b00101, "dis_apply");
    step(0, 0, 0, 0, 0, 5'b00001, "dis_hold");
    step(0, 1, 0, 0, 0, 5'b11001, "reenable");
    step(0, 1, 0, 0, 0, 5'b10001, "p6_hi1");
    step(0, 1, 0, 0, 0, 5'b10001, "p6_hi2");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 5'b00001, "p6_lo");
    step(0, 1, 0, 0, 0, 5'b11001, "p6_tick");
    // 15/14: fits WIDTH=4 exactly.
    step(1, 0, 0, 0, 0, 5'b00000, "rst2");
    step(0, 1, 0, 0, 0, 5'b11001, "rel2");
    step(0, 1, 1, 15, 14, 5'b10000, "offer_15_14");
    step(0, 1, 0, 0, 0, 5'b00000, "old_lo_a");
    step(0, 1, 0, 0, 0, 5'b00000, "old_lo_b");
    step(0, 1, 0, 0, 0, 5'b11101, "apply_15_14");
    for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 0, 5'b10001, "long_hi");
    step(0, 1, 0, 0, 0, 5'b00001, "long_lo");
    step(0, 1, 0, 0, 0, 5'b11001, "long_tick");
    step(0, 1, 0, 0, 0, 5'b10001, "long_hi_again");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d unchecked vectors want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
